// File: rtl/stopwatch_pkg.sv
// Shared constants and state encoding for the BCD stopwatch controller.
package stopwatch_pkg;

   // Width of one BCD decade digit.
   localparam int DIGIT_W = 4;

   // Highest legal BCD digit value; the digit wraps to 0 after it.
   localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

   // Command FSM states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_LAP   = 2'd2,
      ST_PAUSE = 2'd3
   } sw_state_e;

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: counts 0..9 on inc, clears synchronously on clr,
// and signals a carry in the same cycle it wraps from 9 to 0.
module bcd_digit
   import stopwatch_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               inc,
   input  logic               clr,
   output logic [DIGIT_W-1:0] q,
   output logic               carry
);

   logic [DIGIT_W-1:0] q_q;

   // Digit register: clear wins over increment; 9 rolls over to 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_q <= '0;
      end else if (clr) begin
         q_q <= '0;
      end else if (inc) begin
         q_q <= (q_q == BCD_MAX) ? '0 : q_q + 1'b1;
      end
   end

   assign q     = q_q;
   // Carry is combinational so a full chain ripples within one cycle.
   assign carry = inc & (q_q == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Start/stop/lap/clear stopwatch: prescaler, command FSM, lap latch,
// sticky overflow, and a ripple chain of BCD digits.
module bcd_stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int PRESCALE   = 10
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start_stop,
   input  logic                          lap,
   input  logic                          clear,
   output logic [DIGIT_W*NUM_DIGITS-1:0] digits,
   output logic                          running,
   output logic                          lap_active,
   output logic                          tick,
   output logic                          overflow
);

   // Prescaler needs at least one bit even when PRESCALE is 1.
   localparam int             PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);
   localparam int             CW         = DIGIT_W * NUM_DIGITS;

   sw_state_e     state_q;
   logic [PW-1:0] presc_q;
   logic [CW-1:0] latch_q;
   logic          ovf_q;
   logic          tick_q;
   logic          run_q;
   logic          lapact_q;

   logic [NUM_DIGITS-1:0][DIGIT_W-1:0] cnt;
   logic [NUM_DIGITS:0]                inc_c;
   logic [CW-1:0]                      count_flat;
   logic                               active;
   logic                               cnt_inc;
   logic                               cnt_clr;

   // Counting runs in both RUN and LAP; LAP only freezes the display.
   assign active  = (state_q == ST_RUN) || (state_q == ST_LAP);
   assign cnt_inc = active && (presc_q == PRESC_LAST);
   // Clear is honoured only while paused.
   assign cnt_clr = (state_q == ST_PAUSE) && clear;

   assign inc_c[0] = cnt_inc;

   genvar g;
   generate
      for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
         bcd_digit u_digit (
            .clk   (clk),
            .reset (reset),
            .inc   (inc_c[g]),
            .clr   (cnt_clr),
            .q     (cnt[g]),
            .carry (inc_c[g+1])
         );
      end
   endgenerate

   assign count_flat = cnt;

   // Prescaler: advances while counting, holds in PAUSE so a partial
   // interval resumes, and is zeroed when clear sends us back to IDLE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc_q <= '0;
      end else if (cnt_clr) begin
         presc_q <= '0;
      end else if (active) begin
         presc_q <= cnt_inc ? '0 : presc_q + 1'b1;
      end
   end

   // Tick pulse trails the increment edge; overflow is sticky until clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tick_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         tick_q <= cnt_inc;
         if (cnt_clr) begin
            ovf_q <= 1'b0;
         end else if (inc_c[NUM_DIGITS]) begin
            ovf_q <= 1'b1;
         end
      end
   end

   // Command FSM with registered status outputs and the lap latch.
   // Priority clear > start_stop > lap falls out of the if/else order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         latch_q  <= '0;
         run_q    <= 1'b0;
         lapact_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_stop) begin
                  state_q <= ST_RUN;
                  run_q   <= 1'b1;
               end
            end
            ST_RUN: begin
               if (start_stop) begin
                  state_q <= ST_PAUSE;
                  run_q   <= 1'b0;
               end else if (lap) begin
                  // Latch the pre-edge count even if it increments now.
                  state_q  <= ST_LAP;
                  latch_q  <= count_flat;
                  lapact_q <= 1'b1;
               end
            end
            ST_LAP: begin
               if (start_stop) begin
                  state_q  <= ST_PAUSE;
                  run_q    <= 1'b0;
                  lapact_q <= 1'b0;
                  latch_q  <= '0;
               end else if (lap) begin
                  state_q  <= ST_RUN;
                  lapact_q <= 1'b0;
               end
            end
            ST_PAUSE: begin
               if (clear) begin
                  state_q <= ST_IDLE;
               end else if (start_stop) begin
                  state_q <= ST_RUN;
                  run_q   <= 1'b1;
               end
            end
            default: begin
               state_q  <= ST_IDLE;
               run_q    <= 1'b0;
               lapact_q <= 1'b0;
            end
         endcase
      end
   end

   // Display selects between two registers; no path from command inputs.
   assign digits     = lapact_q ? latch_q : count_flat;
   assign running    = run_q;
   assign lap_active = lapact_q;
   assign tick       = tick_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Directed bench for bcd_stopwatch_ctrl with an integer-level reference model.
module tb_bcd_stopwatch_ctrl;

   localparam int ND   = 2;
   localparam int PS   = 4;
   localparam int MAXV = 99;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_LAP   = 2;
   localparam int M_PAUSE = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start_stop = 1'b0;
   logic          lap = 1'b0;
   logic          clear = 1'b0;
   logic [4*ND-1:0] digits;
   logic          running;
   logic          lap_active;
   logic          tick;
   logic          overflow;

   int n_pass = 0;
   int n_tot  = 0;

   // Model: count as a plain integer, prescaler as a phase counter.
   int m_st    = M_IDLE;
   int m_count = 0;
   int m_phase = 0;
   int m_latch = 0;
   bit m_ovf   = 0;
   bit m_tick  = 0;

   bcd_stopwatch_ctrl #(.NUM_DIGITS(ND), .PRESCALE(PS)) dut (
      .clk        (clk),
      .reset      (reset),
      .start_stop (start_stop),
      .lap        (lap),
      .clear      (clear),
      .digits     (digits),
      .running    (running),
      .lap_active (lap_active),
      .tick       (tick),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [4*ND-1:0] to_bcd(input int v);
      logic [4*ND-1:0] r;
      int x;
      r = '0;
      x = v;
      for (int i = 0; i < ND; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic model_reset();
      m_st = M_IDLE; m_count = 0; m_phase = 0; m_latch = 0; m_ovf = 0; m_tick = 0;
   endtask

   // One rising edge of the reference behaviour, using pre-edge values.
   task automatic model_edge(input bit ss, input bit lp, input bit cl);
      bit act, inc;
      int old;
      if (!reset) begin
         model_reset();
         return;
      end
      act = (m_st == M_RUN) || (m_st == M_LAP);
      inc = act && (m_phase == PS - 1);
      old = m_count;
      if (act) m_phase = inc ? 0 : m_phase + 1;
      if (inc) begin
         if (m_count == MAXV) begin
            m_count = 0;
            m_ovf   = 1;
         end else begin
            m_count = m_count + 1;
         end
      end
      m_tick = inc;
      case (m_st)
         M_IDLE:  if (ss) m_st = M_RUN;
         M_RUN:   if (ss) m_st = M_PAUSE;
                  else if (lp) begin m_st = M_LAP; m_latch = old; end
         M_LAP:   if (ss) m_st = M_PAUSE;
                  else if (lp) m_st = M_RUN;
         default: if (cl) begin
                     m_st = M_IDLE; m_count = 0; m_phase = 0; m_ovf = 0;
                  end else if (ss) m_st = M_RUN;
      endcase
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic compare_all();
      chk("m_digits",  32'(digits), 32'(to_bcd((m_st == M_LAP) ? m_latch : m_count)));
      chk("m_running", 32'(running), 32'((m_st == M_RUN) || (m_st == M_LAP)));
      chk("m_lap",     32'(lap_active), 32'(m_st == M_LAP));
      chk("m_tick",    32'(tick), 32'(m_tick));
      chk("m_ovf",     32'(overflow), 32'(m_ovf));
   endtask

   // Drive commands at the falling edge, model the rising edge, compare at the next falling edge.
   task automatic step(input bit ss, input bit lp, input bit cl);
      start_stop = ss; lap = lp; clear = cl;
      @(posedge clk);
      model_edge(ss, lp, cl);
      @(negedge clk);
      start_stop = 0; lap = 0; clear = 0;
      compare_all();
   endtask

   task automatic do_reset();
      reset = 0;
      model_reset();
      repeat (2) step(0, 0, 0);
      reset = 1;
   endtask

   initial begin
      // Reset held for three cycles
      reset = 0;
      model_reset();
      repeat (3) step(0, 0, 0);
      reset = 1;
      chk("rst_digits", 32'(digits), 32'h00);
      chk("rst_running", 32'(running), 0);
      chk("rst_overflow", 32'(overflow), 0);
      step(0, 0, 1);
      step(0, 1, 0);
      chk("idle_ignore_digits", 32'(digits), 32'h00);
      chk("idle_ignore_lap", 32'(lap_active), 0);

      // Count and first-increment latency
      step(1, 0, 0);
      repeat (3) step(0, 0, 0);
      chk("lat_before", 32'(digits), 32'h00);
      step(0, 0, 0);
      chk("lat_first", 32'(digits), 32'h01);
      chk("lat_tick", 32'(tick), 1);
      step(0, 0, 1);                    // clear ignored in RUN
      repeat (35) step(0, 0, 0);
      chk("carry_09_10", 32'(digits), 32'h10);

      // Pause with the prescaler part-way, then resume
      step(0, 0, 0);
      step(1, 0, 0);
      repeat (20) step(0, 0, 0);
      chk("pause_frozen", 32'(digits), 32'h10);
      chk("pause_running", 32'(running), 0);
      step(1, 0, 0);
      step(0, 0, 0);
      chk("resume_no_tick", 32'(tick), 0);
      step(0, 0, 0);
      chk("resume_inc", 32'(digits), 32'h11);
      chk("resume_tick", 32'(tick), 1);

      // Lap freeze / unfreeze
      do_reset();
      step(1, 0, 0);
      repeat (20) step(0, 0, 0);
      chk("lap_pre", 32'(digits), 32'h05);
      step(0, 1, 0);
      chk("lap_frozen", 32'(digits), 32'h05);
      chk("lap_active", 32'(lap_active), 1);
      repeat (15) step(0, 0, 0);
      chk("lap_still", 32'(digits), 32'h05);
      step(0, 1, 0);
      chk("lap_live", 32'(digits), 32'h09);
      chk("lap_off", 32'(lap_active), 0);
      repeat (2) step(0, 0, 0);
      step(0, 1, 0);                    // lap coincides with a tick
      chk("lap_tick_latch", 32'(digits), 32'h09);
      chk("lap_tick_tick", 32'(tick), 1);
      repeat (3) step(0, 0, 0);
      step(1, 0, 0);                    // start_stop coincides with a tick
      chk("ss_tick_digits", 32'(digits), 32'h11);
      chk("ss_tick_running", 32'(running), 0);

      // Overflow wrap and clear
      do_reset();
      step(1, 0, 0);
      repeat (396) step(0, 0, 0);
      chk("ovf_pre", 32'(digits), 32'h99);
      chk("ovf_pre_flag", 32'(overflow), 0);
      repeat (4) step(0, 0, 0);
      chk("ovf_wrap", 32'(digits), 32'h00);
      chk("ovf_flag", 32'(overflow), 1);
      step(1, 0, 0);
      step(1, 0, 1);
      chk("clr_digits", 32'(digits), 32'h00);
      chk("clr_ovf", 32'(overflow), 0);
      chk("clr_running", 32'(running), 0);
      step(0, 0, 0);

      // Asynchronous reset mid-run
      do_reset();
      step(1, 0, 0);
      repeat (148) step(0, 0, 0);
      chk("arst_pre", 32'(digits), 32'h37);
      #2 reset = 0;
      model_reset();
      #1;
      compare_all();
      chk("arst_digits", 32'(digits), 32'h00);
      chk("arst_running", 32'(running), 0);
      @(negedge clk);
      repeat (2) step(0, 0, 0);
      reset = 1;
      repeat (5) step(0, 0, 0);
      chk("arst_idle", 32'(running), 0);
      step(1, 0, 0);
      repeat (4) step(0, 0, 0);
      chk("arst_restart", 32'(digits), 32'h01);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
